mem_bist_master: RTL
====================

# mem_bist_master

Initiator for the memory valid/ready request interface: a self-checking traffic master that writes a deterministic pattern to every location of a `memory` instance, reads every location back, and reports the result. It occupies the initiator seat on the same `clk`/`rst` domain as the memory. It serves as the on-chip BIST engine and as a reusable bus-functional master in memory-level benches.

## Interface

- `WIDTH`, 16, data word width (≥ 8).
- `DEPTH`, 64, number of locations exercised (addresses 0..DEPTH-1).
- `ADDR_WIDTH`, `$clog2(DEPTH)`, address width.
- `TIMEOUT`, 255, maximum stall cycles per beat before abort (≥ 1).

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a test run; sampled only in IDLE or DONE.
- `seed`  in  WIDTH  pattern seed, captured on the edge that accepts `start`.
- `valid`  out  1  request valid toward the memory.
- `wr_rd`  out  1  1 = write, 0 = read.
- `addr`  out  ADDR_WIDTH  request address.
- `wdata`  out  WIDTH  write data (0 during reads).
- `ready`  in  1  memory accepts the beat; a beat transfers on an edge with `valid && ready`.
- `rdata`  in  WIDTH  read data; valid in any cycle where `valid && ready && !wr_rd`.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished; holds until the next accepted `start` or `rst`.
- `pass`  out  1  `done && err_count==0 && !timeout`.
- `timeout`  out  1  run aborted on stall.
- `err_count`  out  ADDR_WIDTH+1  number of read mismatches.
- `first_err_addr`  out  ADDR_WIDTH  address of the first mismatch.

## Operation

- Pattern: `P(a) = rotl(seed, a mod WIDTH) ^ zero_extend(a)`. Example for seed 16'hA5A5: P(0)=16'hA5A5, P(1)=16'h4B4A.
- FSM states: IDLE, WRITE, READ, DONE.
  - IDLE/DONE --start--> WRITE: captures `seed`, sets `addr`=0, clears `done`, `pass`, `timeout`, `err_count` and `first_err_addr`.
  - WRITE: drives `valid`=1, `wr_rd`=1, `wdata`=P(addr). On acceptance at `addr`<DEPTH-1, increments `addr`. On acceptance at DEPTH-1, goes to READ with `addr`=0.
  - READ: drives `valid`=1, `wr_rd`=0, `wdata`=0. On acceptance, compares `rdata` with P(addr).
    - On a mismatch, increments `err_count`.
    - On the first mismatch of the run, latches `first_err_addr`.
    - At `addr`=DEPTH-1, goes to DONE. Otherwise increments `addr`.
  - DONE: `valid`=0, `busy`=0, `done`=1.
- Stall counter: counts consecutive cycles with `valid && !ready`. It clears on every acceptance and on every state entry. When it reaches TIMEOUT, the FSM goes to DONE with `timeout`=1 and `pass`=0; the pending beat is abandoned.
- While `valid && !ready`, `wr_rd`, `addr` and `wdata` hold stable. `valid` never drops without an acceptance, except on timeout or `rst`.
- `start` during WRITE or READ is ignored.
- `err_count` cannot overflow, since its maximum value is DEPTH.

## Timing

- All outputs are registered. Reset values: `valid`=0, `wr_rd`=0, `addr`=0, `wdata`=0, `busy`=0, `done`=0, `pass`=0, `timeout`=0, `err_count`=0, `first_err_addr`=0, state IDLE.
- Start latency: for `start` sampled at edge E0, `valid`=1, `busy`=1, `addr`=0 are visible after E0.
- Zero-wait throughput: one beat per cycle, back-to-back, with no bubble between the last write and the first read.
- Zero-wait run length: write k is accepted at edge E0+k+1 and read k at edge E0+DEPTH+k+1. `done` becomes 1 after edge E0+2·DEPTH.
- The mismatch compare uses `rdata` sampled on the acceptance edge. `err_count` updates on that same edge.
- Timeout: with the stall starting on a beat, `timeout`/`done` assert after the TIMEOUT-th stalled edge.
- `rst` mid-run: the edge sampling `rst`=1 returns every output to its reset value. There is no completion of the pending beat and no `done` pulse.

## Test plan

- **Zero-wait pass.** Stimulus: `ready` tied 1, behavioural memory, seed 16'hA5A5. Required: `wdata`=16'hA5A5 at addr 0 and 16'h4B4A at addr 1. After 2·DEPTH beats, `done`=1, `pass`=1, `err_count`=0, `busy`=0.
- **Injected fault.** Stimulus: the memory returns P(5)^16'h0001 at addr 5. Required: `err_count`=1, `first_err_addr`=5, `pass`=0, `done`=1.
- **Random back-pressure.** Stimulus: `ready` random at 50% with stalls under TIMEOUT. Required: `addr`, `wdata` and `wr_rd` are constant across every stalled cycle; each address is written once and read once; `pass`=1.
- **Timeout.** Stimulus: `ready` stuck 0 from the first beat. Required: after 255 stalled edges, `valid`=0, `timeout`=1, `done`=1, `pass`=0.
- **Reset mid-write.** Stimulus: `rst` pulsed when `addr`=10 during WRITE. Required: all outputs read reset values after that edge. A following `start` runs to completion with `pass`=1.
- **Start while busy.** Stimulus: `start` pulsed during READ at addr 3. Required: the pulse is ignored and the run completes normally. A `start` in DONE clears `done` and begins a new run from addr 0.

Source files
------------

// File: rtl/mem_bist_master.sv
// mem_bist_master: BIST traffic master for a valid/ready memory port.
// It writes P(a) = rotl(seed, a mod WIDTH) ^ a to addresses 0..DEPTH-1,
// reads every location back, compares each read, and reports the result.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, seed       run request pulse (taken in IDLE/DONE) and pattern seed
//   valid, wr_rd,     request toward the memory (wr_rd 1 = write)
//   addr, wdata
//   ready, rdata      memory handshake and read data
//   busy, done, pass, timeout, err_count, first_err_addr   run status
module mem_bist_master #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      seed,
  output logic                  valid,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WIDTH-1:0]      wdata,
  input  logic                  ready,
  input  logic [WIDTH-1:0]      rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam int unsigned CNT_WIDTH   = ADDR_WIDTH + 1;
  localparam int unsigned STALL_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [STALL_WIDTH-1:0] STALL_LIMIT = STALL_WIDTH'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        seed_q, seed_d;
  logic [STALL_WIDTH-1:0]  stall_q, stall_d;
  logic                    valid_q, valid_d;
  logic                    wr_rd_q, wr_rd_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WIDTH-1:0]        wdata_q, wdata_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic                    timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]    err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0]   first_err_addr_q, first_err_addr_d;

  // Rotate-left via a doubled word, then fold in the address.
  function automatic logic [WIDTH-1:0] pattern(input logic [WIDTH-1:0]      s,
                                               input logic [ADDR_WIDTH-1:0] a);
    logic [2*WIDTH-1:0] dbl;
    int unsigned        sh;
    sh  = 32'(a) % WIDTH;
    dbl = {s, s} << sh;
    return dbl[2*WIDTH-1:WIDTH] ^ WIDTH'(a);
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d          = state_q;
    seed_d           = seed_q;
    stall_d          = stall_q;
    valid_d          = valid_q;
    wr_rd_d          = wr_rd_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    busy_d           = busy_q;
    done_d           = done_q;
    pass_d           = pass_q;
    timeout_d        = timeout_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // P(0) is the seed itself, taken straight from the input.
          state_d          = S_WRITE;
          seed_d           = seed;
          stall_d          = '0;
          valid_d          = 1'b1;
          wr_rd_d          = 1'b1;
          addr_d           = '0;
          wdata_d          = seed;
          busy_d           = 1'b1;
          done_d           = 1'b0;
          pass_d           = 1'b0;
          timeout_d        = 1'b0;
          err_count_d      = '0;
          first_err_addr_d = '0;
        end
      end

      S_WRITE, S_READ: begin
        if (ready) begin
          stall_d = '0;
          if (state_q == S_WRITE) begin
            if (addr_q == LAST_ADDR) begin
              // Last write goes straight into the first read, no bubble.
              state_d = S_READ;
              wr_rd_d = 1'b0;
              addr_d  = '0;
              wdata_d = '0;
            end else begin
              addr_d  = addr_q + ADDR_WIDTH'(1);
              wdata_d = pattern(seed_q, addr_q + ADDR_WIDTH'(1));
            end
          end else begin
            if (rdata != pattern(seed_q, addr_q)) begin
              err_count_d = err_count_q + CNT_WIDTH'(1);
              if (err_count_q == '0) begin
                first_err_addr_d = addr_q;
              end
            end
            if (addr_q == LAST_ADDR) begin
              state_d = S_DONE;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = (err_count_d == '0);
            end else begin
              addr_d = addr_q + ADDR_WIDTH'(1);
            end
          end
        end else begin
          stall_d = stall_q + STALL_WIDTH'(1);
          // Abandon the pending beat once the stall budget is used up.
          if (stall_d == STALL_LIMIT) begin
            state_d   = S_DONE;
            stall_d   = '0;
            valid_d   = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            pass_d    = 1'b0;
            timeout_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      seed_q           <= '0;
      stall_q          <= '0;
      valid_q          <= 1'b0;
      wr_rd_q          <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      timeout_q        <= 1'b0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
    end else begin
      state_q          <= state_d;
      seed_q           <= seed_d;
      stall_q          <= stall_d;
      valid_q          <= valid_d;
      wr_rd_q          <= wr_rd_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      timeout_q        <= timeout_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
    end
  end

  assign valid          = valid_q;
  assign wr_rd          = wr_rd_q;
  assign addr           = addr_q;
  assign wdata          = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;

endmodule
